// File: rtl/dreg_pkg.sv
// Shared constants and helpers for the D-register bank.
package dreg_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 4;

  // Ceiling log2; callers pass n >= 2 so the result is at least 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/dreg_read_port.sv
// One registered read port: address range check, write bypass mux and output register.
module dreg_read_port
  import dreg_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = clog2(DefDepth)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        we_i,
  input  logic [AW-1:0]               waddr_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
  input  logic [DEPTH-1:0]            valid_i,
  input  logic                        re_i,
  input  logic [AW-1:0]               raddr_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        rvalid_o
);

  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;
  logic             in_range;
  logic             hit;

  // Decoded mux; an address past the last entry matches nothing and flags out-of-range.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    in_range  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (raddr_i == AW'(i)) begin
        sel_data  = mem_i[i];
        sel_valid = valid_i[i];
        in_range  = 1'b1;
      end
    end
  end

  assign hit = we_i && (waddr_i == raddr_i);

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    if (re_i) begin
      if (!in_range) begin
        rdata_d  = '0;
        rvalid_d = 1'b0;
      end else if (clr_i) begin
        // With bypass the read sees the post-clear state; without it, the old content.
        if (BYPASS != 0) begin
          rdata_d  = '0;
          rvalid_d = 1'b0;
        end else begin
          rdata_d  = sel_data;
          rvalid_d = sel_valid;
        end
      end else if ((BYPASS != 0) && hit) begin
        rdata_d  = wdata_i;
        rvalid_d = 1'b1;
      end else begin
        rdata_d  = sel_data;
        rvalid_d = sel_valid;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/dreg_file.sv
// Bank of DEPTH x WIDTH D registers with per-entry valid bits, one write port,
// synchronous clear-all and two registered read ports.
module dreg_file
  import dreg_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re0,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  output logic             rvalid0,
  input  logic             re1,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid1
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0]            wr_sel;

  // Out-of-range write addresses decode to no entry, so they are dropped.
  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_sel[i] = we && (waddr == AW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      valid_q <= '0;
    end else if (clr) begin
      mem_q   <= '0;
      valid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem_q[i]   <= wdata;
          valid_q[i] <= 1'b1;
        end
      end
    end
  end

  dreg_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .BYPASS(BYPASS),
    .AW    (AW)
  ) u_rd0 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clr),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .mem_i   (mem_q),
    .valid_i (valid_q),
    .re_i    (re0),
    .raddr_i (raddr0),
    .rdata_o (rdata0),
    .rvalid_o(rvalid0)
  );

  dreg_read_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .BYPASS(BYPASS),
    .AW    (AW)
  ) u_rd1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clr),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .mem_i   (mem_q),
    .valid_i (valid_q),
    .re_i    (re1),
    .raddr_i (raddr1),
    .rdata_o (rdata1),
    .rvalid_o(rvalid1)
  );

endmodule

// File: tb/tb_dreg_file.sv
// Bench for dreg_file: three configurations on a shared input bus, checked against a
// behavioural model through a scoreboard queue plus directed constant checks.
module tb_dreg_file;

  localparam int NDUT = 3;
  localparam int unsigned DEP[NDUT] = '{4, 4, 3};
  localparam int unsigned BYP[NDUT] = '{1, 0, 1};

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic       re0, re1;
  logic [1:0] raddr0, raddr1;

  logic [7:0] rd_d [NDUT][2];
  logic       rd_v [NDUT][2];

  int n_checks;
  int n_fail;

  typedef struct {
    int         k;
    int         p;
    logic [7:0] d;
    logic       v;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state per configuration.
  logic [7:0] m_mem [NDUT][4];
  logic       m_val [NDUT][4];
  logic [7:0] m_od  [NDUT][2];
  logic       m_ov  [NDUT][2];

  dreg_file #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re0(re0), .raddr0(raddr0), .rdata0(rd_d[0][0]), .rvalid0(rd_v[0][0]),
    .re1(re1), .raddr1(raddr1), .rdata1(rd_d[0][1]), .rvalid1(rd_v[0][1])
  );

  dreg_file #(.WIDTH(8), .DEPTH(4), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re0(re0), .raddr0(raddr0), .rdata0(rd_d[1][0]), .rvalid0(rd_v[1][0]),
    .re1(re1), .raddr1(raddr1), .rdata1(rd_d[1][1]), .rvalid1(rd_v[1][1])
  );

  dreg_file #(.WIDTH(8), .DEPTH(3), .BYPASS(1)) dut_d3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re0(re0), .raddr0(raddr0), .rdata0(rd_d[2][0]), .rvalid0(rd_v[2][0]),
    .re1(re1), .raddr1(raddr1), .rdata1(rd_d[2][1]), .rvalid1(rd_v[2][1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_mem[k][i] = '0;
        m_val[k][i] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        m_od[k][p] = '0;
        m_ov[k][p] = 1'b0;
      end
    end
  endtask

  // Predict this edge's outputs, update model storage, then clock and compare.
  task automatic cycle();
    logic       re_a [2];
    logic [1:0] ra_a [2];
    exp_t       e;
    re_a[0] = re0;    re_a[1] = re1;
    ra_a[0] = raddr0; ra_a[1] = raddr1;
    for (int k = 0; k < NDUT; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (re_a[p]) begin
          if (int'(ra_a[p]) >= int'(DEP[k])) begin
            m_od[k][p] = '0;
            m_ov[k][p] = 1'b0;
          end else if (clr && BYP[k] == 1) begin
            m_od[k][p] = '0;
            m_ov[k][p] = 1'b0;
          end else if (!clr && we && waddr == ra_a[p] && BYP[k] == 1) begin
            m_od[k][p] = wdata;
            m_ov[k][p] = 1'b1;
          end else begin
            m_od[k][p] = m_mem[k][ra_a[p]];
            m_ov[k][p] = m_val[k][ra_a[p]];
          end
        end
        e.k = k; e.p = p; e.d = m_od[k][p]; e.v = m_ov[k][p];
        exp_q.push_back(e);
      end
      if (clr) begin
        for (int i = 0; i < 4; i++) begin
          m_mem[k][i] = '0;
          m_val[k][i] = 1'b0;
        end
      end else if (we && int'(waddr) < int'(DEP[k])) begin
        m_mem[k][waddr] = wdata;
        m_val[k][waddr] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("sb_d%0d_p%0d_data", e.k, e.p), 32'(rd_d[e.k][e.p]), 32'(e.d));
      check_eq($sformatf("sb_d%0d_p%0d_valid", e.k, e.p), 32'(rd_v[e.k][e.p]), 32'(e.v));
    end
  endtask

  task automatic idle();
    clr = 1'b0; we = 1'b0; re0 = 1'b0; re1 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re0 = 1'b0; re1 = 1'b0; raddr0 = '0; raddr1 = '0;
    model_reset();
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("rst_d%0d_rdata0", k), 32'(rd_d[k][0]), 32'h0);
      check_eq($sformatf("rst_d%0d_rvalid1", k), 32'(rd_v[k][1]), 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Two writes, then a dual read.
    idle(); we = 1'b1; waddr = 2'd1; wdata = 8'hA5; cycle();
    waddr = 2'd3; wdata = 8'h3C; cycle();
    idle(); re0 = 1'b1; raddr0 = 2'd1; re1 = 1'b1; raddr1 = 2'd3; cycle();
    check_eq("t2_rdata0", 32'(rd_d[0][0]), 32'hA5);
    check_eq("t2_rdata1", 32'(rd_d[0][1]), 32'h3C);
    check_eq("t2_rvalid0", 32'(rd_v[0][0]), 32'h1);
    check_eq("t2_rvalid1", 32'(rd_v[0][1]), 32'h1);
    check_eq("t5_d3_addr3_rvalid", 32'(rd_v[2][1]), 32'h0);

    // Read strobe low while the entry is rewritten: output holds.
    idle(); we = 1'b1; waddr = 2'd1; wdata = 8'h5A;
    repeat (3) cycle();
    check_eq("t6_hold_rdata0", 32'(rd_d[0][0]), 32'hA5);
    check_eq("t6_hold_rvalid0", 32'(rd_v[0][0]), 32'h1);

    // Same-cycle write/read collision.
    idle(); we = 1'b1; waddr = 2'd2; wdata = 8'h77; re0 = 1'b1; raddr0 = 2'd2; cycle();
    check_eq("t3_byp_rdata0", 32'(rd_d[0][0]), 32'h77);
    check_eq("t3_byp_rvalid0", 32'(rd_v[0][0]), 32'h1);
    check_eq("t3_nobyp_rdata0", 32'(rd_d[1][0]), 32'h00);
    check_eq("t3_nobyp_rvalid0", 32'(rd_v[1][0]), 32'h0);
    idle(); re0 = 1'b1; raddr0 = 2'd2; cycle();
    check_eq("t3_nobyp_later", 32'(rd_d[1][0]), 32'h77);

    // Fill all entries; the DEPTH=3 bank must ignore address 3.
    for (int i = 0; i < 4; i++) begin
      idle(); we = 1'b1; waddr = 2'(i); wdata = 8'(8'h10 + i); cycle();
    end
    idle(); we = 1'b1; waddr = 2'd3; wdata = 8'h12; cycle();
    idle(); re0 = 1'b1; raddr0 = 2'd3; re1 = 1'b1; raddr1 = 2'd2; cycle();
    check_eq("t5_oor_rdata0", 32'(rd_d[2][0]), 32'h00);
    check_eq("t5_oor_rvalid0", 32'(rd_v[2][0]), 32'h0);
    check_eq("t5_entry2", 32'(rd_d[2][1]), 32'h12);
    check_eq("t5_full_depth_addr3", 32'(rd_d[0][0]), 32'h12);
    for (int i = 0; i < 3; i++) begin
      idle(); re0 = 1'b1; raddr0 = 2'(i); re1 = 1'b1; raddr1 = 2'(i); cycle();
    end

    // Clear with a same-cycle write to 0: the write is dropped.
    idle(); clr = 1'b1; we = 1'b1; waddr = 2'd0; wdata = 8'hFF;
    re0 = 1'b1; raddr0 = 2'd0; re1 = 1'b1; raddr1 = 2'd1; cycle();
    check_eq("t4_clr_nobyp_old", 32'(rd_d[1][1]), 32'h11);
    for (int i = 0; i < 4; i++) begin
      idle(); re0 = 1'b1; raddr0 = 2'(i); re1 = 1'b1; raddr1 = 2'(3 - i); cycle();
      check_eq($sformatf("t4_after_clr_a%0d", i), 32'(rd_d[0][0]), 32'h0);
      check_eq($sformatf("t4_after_clr_v%0d", i), 32'(rd_v[0][0]), 32'h0);
    end

    // Random traffic through the scoreboard.
    for (int n = 0; n < 60; n++) begin
      clr    = ($urandom_range(0, 11) == 0);
      we     = 1'($urandom_range(0, 1));
      waddr  = 2'($urandom_range(0, 3));
      wdata  = 8'($urandom);
      re0    = 1'($urandom_range(0, 1));
      raddr0 = 2'($urandom_range(0, 3));
      re1    = 1'($urandom_range(0, 1));
      raddr1 = ($urandom_range(0, 3) == 0) ? raddr0 : 2'($urandom_range(0, 3));
      cycle();
    end

    // Ensure nonzero outputs, then reset asynchronously between edges.
    idle(); we = 1'b1; waddr = 2'd2; wdata = 8'hC3; re0 = 1'b1; raddr0 = 2'd2;
    re1 = 1'b1; raddr1 = 2'd2; cycle();
    check_eq("pre_rst_rdata0", 32'(rd_d[0][0]), 32'hC3);
    check_eq("same_addr_both_ports", 32'(rd_d[0][1]), 32'hC3);
    idle();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < NDUT; k++) begin
      for (int p = 0; p < 2; p++) begin
        check_eq($sformatf("t1_async_d%0d_p%0d_data", k, p), 32'(rd_d[k][p]), 32'h0);
        check_eq($sformatf("t1_async_d%0d_p%0d_valid", k, p), 32'(rd_v[k][p]), 32'h0);
      end
    end
    model_reset();
    #2;
    rst_n = 1'b1;
    re0 = 1'b1; raddr0 = 2'd2; cycle();
    check_eq("t1_post_rst_rdata0", 32'(rd_d[0][0]), 32'h00);
    check_eq("t1_post_rst_rvalid0", 32'(rd_v[0][0]), 32'h0);
    idle(); we = 1'b1; waddr = 2'd0; wdata = 8'h9E; cycle();
    idle(); re0 = 1'b1; raddr0 = 2'd0; cycle();
    check_eq("t1_first_write", 32'(rd_d[0][0]), 32'h9E);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
